// File: rtl/scan_pkg.sv
// Shared definitions for the scan_seq channel sequencer and its helpers.
// Channel count, index width, FSM encoding and default blanking length.
package scan_pkg;

  localparam int NUM_CH           = 8;
  localparam int IDX_W            = 3;
  localparam int DEF_BLANK_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_pick.sv
// Combinational circular next-set-bit finder: nearest set mask bit strictly
// above cur_i, wrapping 7->0; cur_i itself is the last candidate.
module scan_pick
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [IDX_W-1:0]  cur_i,
  output logic [IDX_W-1:0]  next_o,
  output logic              wrap_o,
  output logic              none_o
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest offset down so the nearest hit is written last.
  always_comb begin
    idx    = '0;
    next_o = cur_i;
    none_o = 1'b1;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = cur_i + IDX_W'(i);
      if (mask_i[idx]) begin
        next_o = idx;
        none_o = 1'b0;
      end
    end
    wrap_o = !none_o && (next_o <= cur_i);
  end

endmodule

// File: rtl/scan_seq.sv
// Time-multiplexed channel sequencer feeding a 3-to-8 decoder.
// Define SCAN_BLANK_EN to insert a BLANK_CYCLES enable-low gap between channels.
module scan_seq
  import scan_pkg::*;
#(
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NUM_CH-1:0]  chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [IDX_W-1:0]   sel,
  output logic               sel_en,
  output logic               busy,
  output logic               frame_done
);

  // Counter must hold both the dwell value and the blanking length.
  localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
  localparam int CNT_W = (DWELL_W > BLK_W) ? DWELL_W : BLK_W;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  scan_state_e      state_q;
  logic [IDX_W-1:0] sel_q;
  logic             sel_en_q;
  logic             busy_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CNT_W-1:0] dwell_ld;
  logic [IDX_W-1:0] pick_cur;
  logic [IDX_W-1:0] pick_next;
  logic             pick_wrap;
  logic             pick_none;
  logic             at_boundary;

  assign dwell_ld = (dwell == '0) ? ONE : CNT_W'(dwell);

  // From IDLE, searching above index 7 yields the lowest set bit.
  assign pick_cur = (state_q == IDLE) ? IDX_W'(NUM_CH - 1) : sel_q;

  scan_pick u_pick (
    .mask_i (chan_mask),
    .cur_i  (pick_cur),
    .next_o (pick_next),
    .wrap_o (pick_wrap),
    .none_o (pick_none)
  );

`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES);
  assign at_boundary = (state_q == BLANK) && (cnt_q <= ONE);
`else
  assign at_boundary = (state_q == ACTIVE) && (cnt_q <= ONE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      sel_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (stop) begin
        state_q  <= IDLE;
        sel_en_q <= 1'b0;
        busy_q   <= 1'b0;
        cnt_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !pick_none) begin
              state_q      <= ACTIVE;
              sel_q        <= pick_next;
              sel_en_q     <= 1'b1;
              busy_q       <= 1'b1;
              frame_done_q <= pick_wrap;
              cnt_q        <= dwell_ld;
            end
          end
          ACTIVE: begin
            if (cnt_q > ONE) begin
              cnt_q <= cnt_q - ONE;
            end
`ifdef SCAN_BLANK_EN
            else begin
              state_q  <= BLANK;
              sel_en_q <= 1'b0;
              cnt_q    <= BLANK_LD;
            end
          end
          BLANK: begin
            if (cnt_q > ONE) begin
              cnt_q <= cnt_q - ONE;
            end
`endif
          end
          default: begin
            state_q  <= IDLE;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
          end
        endcase

        // Channel boundary: mask is sampled here and only here.
        if (at_boundary) begin
          if (pick_none) begin
            state_q  <= IDLE;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
          end else begin
            state_q      <= ACTIVE;
            sel_q        <= pick_next;
            sel_en_q     <= 1'b1;
            frame_done_q <= pick_wrap;
            cnt_q        <= dwell_ld;
          end
        end
      end
    end
  end

  assign sel        = sel_q;
  assign sel_en     = sel_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
